// File: rtl/text_window_feeder_pkg.sv
// Shared definitions for the text window feeder and the matcher stage that consumes its windows.
package text_window_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream
  } feeder_state_e;

  // Default geometry of the string matcher
  localparam int unsigned DefDwidth = 8;
  localparam int unsigned DefStrlen = 50;
  localparam int unsigned DefNum    = 4;
  localparam int unsigned DefGroups = 4;

  // Derived widths for the default geometry: window width and text address width
  localparam int unsigned W  = DefNum * DefGroups;
  localparam int unsigned AW = $clog2(DefStrlen);

  // Address width for an index space of n entries, never narrower than one bit
  function automatic int unsigned addr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// Elaboration-time guard: the text must be at least one window long
`define TWF_ASSERT_STRLEN_GE_W(len, w) \
  if ((len) < (w)) begin : g_strlen_check \
    $error("text_window_feeder: strlen must be >= window width"); \
  end

// File: rtl/window_shift_reg.sv
// W x DWIDTH window register; each shift moves every byte down one slot and loads the top byte.
module window_shift_reg #(
  parameter int unsigned W      = 16,
  parameter int unsigned DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [DWIDTH-1:0]     top_in,
  output logic [W*DWIDTH-1:0]   data
);

  logic [W*DWIDTH-1:0] data_q;

  // Byte 0 sits in the low bits; the new byte enters at the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (shift_en) begin
      data_q <= {top_in, data_q[W*DWIDTH-1:DWIDTH]};
    end
  end

  assign data = data_q;

endmodule

// File: rtl/text_window_feeder.sv
// Streams the text memory into a sliding window of W bytes, one window per handshake.
module text_window_feeder
  import text_window_feeder_pkg::*;
#(
  parameter int unsigned DWIDTH               = DefDwidth,
  parameter int unsigned strlen               = DefStrlen,
  parameter int unsigned num                  = DefNum,
  parameter int unsigned groups               = DefGroups,
  parameter int unsigned max_number_of_weight = num * groups,
  localparam int unsigned WinBytes            = max_number_of_weight,
  localparam int unsigned AddrW               = addr_width(strlen)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [AddrW-1:0]             mem_addr,
  input  logic [DWIDTH-1:0]            mem_rdata,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [WinBytes*DWIDTH-1:0]   win_data,
  output logic [WinBytes-1:0]          win_mask,
  output logic [AddrW-1:0]             win_pos,
  output logic                         win_last,
  output logic                         busy,
  output logic                         done
);

  `TWF_ASSERT_STRLEN_GE_W(strlen, WinBytes)

  localparam int unsigned KW         = addr_width(WinBytes + 1);
  // nidx is one bit wider than an address so it can run past the text end without wrapping
  localparam int unsigned NidxMaxRep = (1 << (AddrW + 1)) - 1;
  localparam int unsigned NidxSat    = (strlen + WinBytes > NidxMaxRep) ? NidxMaxRep
                                                                        : strlen + WinBytes;
  localparam logic [KW-1:0]    KLast     = KW'(WinBytes);
  localparam logic [AddrW:0]   NidxStart = (AddrW + 1)'(WinBytes);
  localparam logic [AddrW:0]   NidxEnd   = (AddrW + 1)'(NidxSat);
  localparam logic [AddrW:0]   TextLen   = (AddrW + 1)'(strlen);
  localparam logic [AddrW:0]   LastIdxW  = (AddrW + 1)'(strlen - 1);
  localparam logic [AddrW-1:0] LastAddr  = AddrW'(strlen - 1);

  feeder_state_e state_q, state_d;

  logic [KW-1:0]               k_q, k_d;
  logic [AddrW:0]              nidx_q, nidx_d;
  logic [AddrW-1:0]            pos_q, pos_d;
  logic                        done_q, done_d;

  logic                        in_stream;
  logic                        hs;
  logic                        pos_is_last;
  logic                        shift_en;
  logic [DWIDTH-1:0]           top_byte;
  logic [AddrW:0]              fetch_idx;
  logic [WinBytes-1:0]         mask_raw;
  logic [WinBytes*DWIDTH-1:0]  window;

  assign in_stream   = (state_q == StStream);
  assign hs          = in_stream & win_ready;
  assign pos_is_last = (pos_q == LastAddr);

  window_shift_reg #(
    .W      (WinBytes),
    .DWIDTH (DWIDTH)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .top_in   (top_byte),
    .data     (window)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fill the window, stream it, return to idle after the last window is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFill;
      StFill:   if (k_q == KLast) state_d = StStream;
      StStream: if (hs && pos_is_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Counter and window-shift control
  always_comb begin
    k_d      = k_q;
    nidx_d   = nidx_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    top_byte = mem_rdata;
    unique case (state_q)
      StIdle: begin
        k_d    = '0;
        nidx_d = '0;
        pos_d  = '0;
      end
      StFill: begin
        // Read data lags the address by one cycle, so the first fill cycle has nothing to load
        shift_en = (k_q != '0);
        if (k_q == KLast) begin
          k_d    = '0;
          nidx_d = NidxStart;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StStream: begin
        if (hs) begin
          shift_en = 1'b1;
          // Positions past the text end are padded with zero bytes
          top_byte = (nidx_q < TextLen) ? mem_rdata : '0;
          nidx_d   = (nidx_q == NidxEnd) ? nidx_q : nidx_q + (AddrW + 1)'(1);
          pos_d    = pos_is_last ? '0 : pos_q + AddrW'(1);
          done_d   = pos_is_last;
        end
      end
      default: ;
    endcase
  end

  // Counters and the end-of-pass pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= '0;
      nidx_q <= '0;
      pos_q  <= '0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      nidx_q <= nidx_d;
      pos_q  <= pos_d;
      done_q <= done_d;
    end
  end

  // Validity mask: bit i set while win_pos + i still lies inside the text
  always_comb begin
    mask_raw = '0;
    for (int unsigned i = 0; i < WinBytes; i++) begin
      mask_raw[i] = ((32'(pos_q) + i) < strlen);
    end
  end

  // Outputs: zero when idle; address looks one byte ahead on a handshake so there are no bubbles
  always_comb begin
    win_valid = 1'b0;
    busy      = 1'b0;
    win_data  = '0;
    win_mask  = '0;
    win_pos   = '0;
    win_last  = 1'b0;
    fetch_idx = '0;
    unique case (state_q)
      StIdle: ;
      StFill: begin
        busy      = 1'b1;
        fetch_idx = (AddrW + 1)'(k_q);
      end
      StStream: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        fetch_idx = nidx_q + (AddrW + 1)'(hs);
        win_data  = window;
        win_mask  = mask_raw;
        win_pos   = pos_q;
        win_last  = pos_is_last;
      end
      default: ;
    endcase
    mem_addr = (fetch_idx > LastIdxW) ? LastAddr : fetch_idx[AddrW-1:0];
    done     = done_q;
  end

endmodule

// File: doc/text_window_feeder.md
# text_window_feeder

Upstream feed stage of the parallel string matcher. It streams the stored text (strlen bytes of DWIDTH bits) out of a synchronous text memory and presents the matcher's comparator groups with a sliding window of max_number_of_weight consecutive bytes per position. It delivers one window per cycle under a valid/ready handshake, plus a validity mask for windows that run past the end of the text.

## Interface

Parameters:
- DWIDTH, 8, bits per character
- strlen, 50, text length in characters; must be ≥ max_number_of_weight (elaboration-time check)
- num, 4, comparators per group
- groups, 4, comparator groups
- max_number_of_weight, num*groups (16), window width W in characters

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a pass over the text; sampled only in IDLE
- mem_addr  out  AW = $clog2(strlen)  text memory read address
- mem_rdata  in  DWIDTH  text memory data, 1-cycle synchronous read latency
- win_valid  out  1  window valid
- win_ready  in  1  matcher accepts window
- win_data  out  W*DWIDTH  byte i = text[win_pos+i] in bits [i*DWIDTH +: DWIDTH]
- win_mask  out  W  bit i = 1 iff win_pos+i < strlen
- win_pos  out  AW  start index of the presented window
- win_last  out  1  win_pos == strlen-1
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of pass

## Operation

- States: IDLE → FILL → STREAM → IDLE. An async reset forces IDLE from any state.
- IDLE: all outputs are 0 (mem_addr 0). start=1 → FILL next cycle. Clear fill counter k, fetch index nidx, and win_pos.
- FILL: lasts W+1 cycles. The cycle with counter k drives mem_addr=k for k = 0..W, clamped to strlen-1. Starting on the second FILL cycle, mem_rdata shifts into the top byte of the window register, which moves all bytes down one position. After W shifts, byte 0 = text[0]. On the last FILL cycle, address W is issued as a prefetch and nidx=W. → STREAM.
- STREAM: win_valid=1. A handshake is win_valid & win_ready.
  - On a handshake, the window shifts down one byte and win_pos increments. The incoming top byte is mem_rdata if nidx < strlen, else 0. nidx then increments, saturating at strlen+W.
  - mem_addr is combinational lookahead: min(nidx + handshake, strlen-1). The prefetched byte is therefore always ready for a back-to-back handshake, with no bubbles.
  - Without a handshake, every output and the address hold stable.
- win_mask is computed from win_pos: a bit is cleared where win_pos+i ≥ strlen. Padded bytes are always 0.
- Handshake with win_last=1 → IDLE, with done=1 for that one cycle. done coincides with the first IDLE cycle.
- A pass produces exactly strlen windows, win_pos 0..strlen-1.
- start asserted outside IDLE is ignored. start on the cycle done is high starts a new pass immediately.
- win_ready outside STREAM is ignored.

## Timing

- Start sampled at edge t0. FILL occupies t0+1..t0+W+1 and STREAM begins at t0+W+2. With W=16 that is the 18th cycle after start.
- Sustained throughput is 1 window/cycle with win_ready high. A full pass takes W+1+strlen cycles (67 at defaults).
- Latency from a handshake to the next window on outputs is 1 cycle. Stall holds all outputs with no limit on duration.
- Reset value of every output is 0. After reset, the first start behaves as from IDLE.
- Width rules: win_pos and mem_addr are AW bits. nidx is AW+1 bits so the comparison past strlen does not wrap.

## Structure

- Shared package: the state enum {IDLE, FILL, STREAM}, the AW/W derived-width localparams, and the strlen ≥ W assertion macro. The matcher stage already consumes W and AW from this package.
- One natural sub-module: window_shift_reg (W×DWIDTH register with a shift-down enable and a top-byte input). The FSM, counters and mask logic stay in text_window_feeder.

## Test plan

- Text "A".."Z" then "a"..x (50 bytes); start with win_ready=1 → first window at cycle 18, win_data bytes "A".."P", mask 0xFFFF, win_pos 0. Expect 50 consecutive windows and done at cycle 68.
- Same run with win_ready toggling 1-0-0-1 → outputs stable during stalls. Window sequence identical to the ungated run; no skipped or duplicated win_pos.
- Tail check: at win_pos 40 the mask is 0x03FF and bytes 10..15 are 0. At win_pos 49 the mask is 0x0001, win_last=1, mem_addr stays ≤ 49.
- start pulsed during FILL and during STREAM → ignored, pass unaffected. start on the done cycle → second identical pass with no gap beyond FILL.
- Reset asserted mid-STREAM (win_pos 20) → all outputs 0 immediately. A following start produces a full pass from win_pos 0.
- Memory model returns X unless mem_addr < strlen → no X on win_data in any valid window.
